// File: rtl/fatori_mon_voter.sv
// N-lane redundant result voter: M-of-N agreement with registered outputs, held error
// flags, per-lane loss streaks that mask persistently failing lanes, and an error counter.
module fatori_mon_voter #(
    parameter int N           = 3,
    parameter int M           = 2,
    parameter int WIDTH       = 32,
    parameter int HOLD        = 4,
    parameter int DISABLE_THR = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N-1:0]       lane_valid_i,
    input  logic [N*WIDTH-1:0] lane_data_i,
    input  logic               clear_i,
    output logic [WIDTH-1:0]   data_o,
    output logic               valid_o,
    output logic               min_err_o,
    output logic               maj_err_o,
    output logic [N-1:0]       lane_fault_o,
    output logic [7:0]         err_cnt_o
);

    localparam int CW = $clog2(N + 1);
    localparam int IW = $clog2(N);
    localparam int SW = (DISABLE_THR > 0) ? $clog2(DISABLE_THR + 1) : 1;
    localparam int HW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;

    localparam logic [CW-1:0] M_CNT      = CW'(M);
    localparam logic [SW-1:0] STREAK_MAX = SW'(DISABLE_THR);
    localparam logic [HW-1:0] HOLD_INIT  = HW'(HOLD);

    // Registered state
    logic [WIDTH-1:0] data_q,     data_d;
    logic             valid_q,    valid_d;
    logic             min_err_q,  min_err_d;
    logic             maj_err_q,  maj_err_d;
    logic [HW-1:0]    min_hold_q, min_hold_d;
    logic [HW-1:0]    maj_hold_q, maj_hold_d;
    logic [N-1:0]     mask_q,     mask_d;
    logic [SW-1:0]    streak_q [N];
    logic [SW-1:0]    streak_d [N];
    logic [7:0]       err_cnt_q,  err_cnt_d;

    // Vote evaluation
    logic [WIDTH-1:0] lane_data [N];
    logic [CW-1:0]    agree_cnt [N];
    logic [N-1:0]     part_valid;
    logic [N-1:0]     lane_agree;
    logic             vote;
    logic             win_found;
    logic             first_found;
    logic [IW-1:0]    win_idx;
    logic [IW-1:0]    first_idx;
    logic [IW-1:0]    sel_idx;
    logic             maj_ev;
    logic             min_ev;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            lane_data[k] = lane_data_i[k*WIDTH +: WIDTH];
        end

        part_valid  = lane_valid_i & ~mask_q;
        vote        = |part_valid;
        win_found   = 1'b0;
        win_idx     = '0;
        first_found = 1'b0;
        first_idx   = '0;
        lane_agree  = '0;

        for (int k = 0; k < N; k++) begin
            agree_cnt[k] = '0;
            for (int j = 0; j < N; j++) begin
                if (part_valid[j] && (lane_data[j] == lane_data[k])) begin
                    agree_cnt[k] = agree_cnt[k] + CW'(1);
                end
            end
        end

        // Ascending scan with "found" guards picks the lowest-indexed lane.
        for (int k = 0; k < N; k++) begin
            if (!first_found && part_valid[k]) begin
                first_found = 1'b1;
                first_idx   = IW'(k);
            end
            if (!win_found && part_valid[k] && (agree_cnt[k] >= M_CNT)) begin
                win_found = 1'b1;
                win_idx   = IW'(k);
            end
        end

        sel_idx = win_found ? win_idx : first_idx;
        maj_ev  = vote && !win_found;

        for (int k = 0; k < N; k++) begin
            lane_agree[k] = part_valid[k] && win_found && (lane_data[k] == lane_data[win_idx]);
        end

        // An unmasked lane that is invalid or differs from the winner is a minority error.
        min_ev = vote && (maj_ev || |(~mask_q & ~lane_agree));
    end

    // Result register: data holds across idle cycles, valid marks a vote.
    always_comb begin
        valid_d = vote;
        data_d  = data_q;
        if (vote) begin
            data_d = lane_data[sel_idx];
        end
    end

    // Error flags restart their hold window on every new event.
    always_comb begin
        min_err_d  = 1'b0;
        min_hold_d = '0;
        if (min_ev) begin
            min_err_d  = 1'b1;
            min_hold_d = HOLD_INIT;
        end else if (min_hold_q != '0) begin
            min_err_d  = 1'b1;
            min_hold_d = min_hold_q - HW'(1);
        end

        maj_err_d  = 1'b0;
        maj_hold_d = '0;
        if (maj_ev) begin
            maj_err_d  = 1'b1;
            maj_hold_d = HOLD_INIT;
        end else if (maj_hold_q != '0) begin
            maj_err_d  = 1'b1;
            maj_hold_d = maj_hold_q - HW'(1);
        end
    end

    // Streaks, lane mask and error count; clear wins over the vote's own updates.
    always_comb begin
        int remain;
        streak_d  = streak_q;
        mask_d    = mask_q;
        err_cnt_d = err_cnt_q;
        remain    = 0;

        for (int k = 0; k < N; k++) begin
            if (!mask_q[k]) begin
                remain = remain + 1;
            end
        end

        if (vote) begin
            for (int k = 0; k < N; k++) begin
                if (!mask_q[k]) begin
                    if (maj_ev || !lane_agree[k]) begin
                        if (streak_q[k] != STREAK_MAX) begin
                            streak_d[k] = streak_q[k] + SW'(1);
                        end
                    end else begin
                        streak_d[k] = '0;
                    end
                end
            end

            // Mask in index order while at least M lanes would still participate.
            if (DISABLE_THR > 0) begin
                for (int k = 0; k < N; k++) begin
                    if (!mask_q[k] && (streak_d[k] == STREAK_MAX) && (remain > M)) begin
                        mask_d[k] = 1'b1;
                        remain    = remain - 1;
                    end
                end
            end

            if (min_ev && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end

        if (clear_i) begin
            mask_d    = '0;
            err_cnt_d = '0;
            for (int k = 0; k < N; k++) begin
                streak_d[k] = '0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            min_err_q  <= 1'b0;
            maj_err_q  <= 1'b0;
            min_hold_q <= '0;
            maj_hold_q <= '0;
            mask_q     <= '0;
            err_cnt_q  <= '0;
            for (int k = 0; k < N; k++) begin
                streak_q[k] <= '0;
            end
        end else begin
            data_q     <= data_d;
            valid_q    <= valid_d;
            min_err_q  <= min_err_d;
            maj_err_q  <= maj_err_d;
            min_hold_q <= min_hold_d;
            maj_hold_q <= maj_hold_d;
            mask_q     <= mask_d;
            err_cnt_q  <= err_cnt_d;
            for (int k = 0; k < N; k++) begin
                streak_q[k] <= streak_d[k];
            end
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign min_err_o    = min_err_q;
    assign maj_err_o    = maj_err_q;
    assign lane_fault_o = mask_q;
    assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_fatori_mon_voter.sv
// Self-checking bench for fatori_mon_voter: a behavioural model feeds a scoreboard queue
// every cycle, and scenario tasks add directed checks of the key behaviours.
module tb_fatori_mon_voter;

    localparam int N     = 3;
    localparam int M     = 2;
    localparam int WIDTH = 32;
    localparam int HOLD  = 4;
    localparam int THR   = 3;

    logic               clk;
    logic               rst;
    logic               clear;
    logic [N-1:0]       lane_valid;
    logic [N*WIDTH-1:0] lane_data;
    logic [WIDTH-1:0]   data_o;
    logic               valid_o;
    logic               min_err_o;
    logic               maj_err_o;
    logic [N-1:0]       lane_fault_o;
    logic [7:0]         err_cnt_o;

    fatori_mon_voter #(
        .N           (N),
        .M           (M),
        .WIDTH       (WIDTH),
        .HOLD        (HOLD),
        .DISABLE_THR (THR)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .lane_valid_i (lane_valid),
        .lane_data_i  (lane_data),
        .clear_i      (clear),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .min_err_o    (min_err_o),
        .maj_err_o    (maj_err_o),
        .lane_fault_o (lane_fault_o),
        .err_cnt_o    (err_cnt_o)
    );

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             valid;
        logic             min_err;
        logic             maj_err;
        logic [N-1:0]     fault;
        logic [7:0]       err_cnt;
    } obs_t;

    obs_t exp_q[$];
    int   tests_run;
    int   tests_failed;

    // Reference model state
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic [N-1:0]     m_mask;
    int               m_streak [N];
    int               m_err;
    int               m_min_left;
    int               m_maj_left;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N*WIDTH-1:0] lanes(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [WIDTH-1:0] c);
        return {c, b, a};
    endfunction

    task automatic model_step(input logic [N-1:0] v, input logic [N*WIDTH-1:0] d,
                              input logic clr, input logic r);
        logic [WIDTH-1:0] ld [N];
        logic [N-1:0]     part;
        logic [N-1:0]     new_mask;
        logic             maj;
        logic             minor;
        logic             agree;
        int               win;
        int               first;
        int               cnt;
        int               remain;
        obs_t             e;
        for (int i = 0; i < N; i++) ld[i] = d[i*WIDTH +: WIDTH];
        if (r) begin
            m_data     = '0;
            m_valid    = 1'b0;
            m_mask     = '0;
            m_err      = 0;
            m_min_left = 0;
            m_maj_left = 0;
            for (int i = 0; i < N; i++) m_streak[i] = 0;
            e = '0;
            exp_q.push_back(e);
            return;
        end
        part    = v & ~m_mask;
        m_valid = (part != '0);
        if (m_valid) begin
            win   = -1;
            first = -1;
            for (int i = 0; i < N; i++) begin
                if (part[i]) begin
                    if (first < 0) first = i;
                    cnt = 0;
                    for (int j = 0; j < N; j++) if (part[j] && ld[j] == ld[i]) cnt++;
                    if (cnt >= M && win < 0) win = i;
                end
            end
            maj    = (win < 0);
            m_data = maj ? ld[first] : ld[win];
            minor  = maj;
            for (int i = 0; i < N; i++) begin
                if (!m_mask[i]) begin
                    agree = 1'b0;
                    if (!maj && part[i]) agree = (ld[i] == m_data);
                    if (!agree) begin
                        minor = 1'b1;
                        if (m_streak[i] < THR) m_streak[i]++;
                    end else begin
                        m_streak[i] = 0;
                    end
                end
            end
            remain = 0;
            for (int i = 0; i < N; i++) if (!m_mask[i]) remain++;
            new_mask = m_mask;
            for (int i = 0; i < N; i++) begin
                if (!m_mask[i] && m_streak[i] >= THR && remain > M) begin
                    new_mask[i] = 1'b1;
                    remain--;
                end
            end
            m_mask = new_mask;
            if (minor && m_err < 255) m_err++;
            if (maj) m_maj_left = HOLD + 1;
            if (minor) m_min_left = HOLD + 1;
        end
        if (clr) begin
            m_mask = '0;
            m_err  = 0;
            for (int i = 0; i < N; i++) m_streak[i] = 0;
        end
        e.data    = m_data;
        e.valid   = m_valid;
        e.min_err = (m_min_left > 0);
        e.maj_err = (m_maj_left > 0);
        e.fault   = m_mask;
        e.err_cnt = 8'(m_err);
        if (m_min_left > 0) m_min_left--;
        if (m_maj_left > 0) m_maj_left--;
        exp_q.push_back(e);
    endtask

    // One clock: apply inputs, queue the model's prediction, then pop it against the DUT.
    task automatic drive(input logic [N-1:0] v, input logic [N*WIDTH-1:0] d,
                         input logic clr, input logic r);
        obs_t e;
        obs_t a;
        lane_valid = v;
        lane_data  = d;
        clear      = clr;
        rst        = r;
        model_step(v, d, clr, r);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        a = {data_o, valid_o, min_err_o, maj_err_o, lane_fault_o, err_cnt_o};
        tests_run++;
        if (a !== e) begin
            tests_failed++;
            $display("FAIL scoreboard @%0t: got data=%h valid=%b min=%b maj=%b fault=%b cnt=%0d; expected data=%h valid=%b min=%b maj=%b fault=%b cnt=%0d",
                     $time, a.data, a.valid, a.min_err, a.maj_err, a.fault, a.err_cnt,
                     e.data, e.valid, e.min_err, e.maj_err, e.fault, e.err_cnt);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        drive('0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        drive('1, lanes(32'h7, 32'h7, 32'h7), 1'b1, 1'b1);
        tests_run++;
        if ({data_o, valid_o, min_err_o, maj_err_o, lane_fault_o, err_cnt_o} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: got data=%h valid=%b min=%b maj=%b fault=%b cnt=%0d, required all zero",
                     data_o, valid_o, min_err_o, maj_err_o, lane_fault_o, err_cnt_o);
        end
    endtask

    task automatic test_unanimous();
        do_reset();
        drive(3'b111, lanes(32'h1234, 32'h1234, 32'h1234), 1'b0, 1'b0);
        tests_run++;
        if (data_o !== 32'h1234 || valid_o !== 1'b1 || min_err_o !== 1'b0 || maj_err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL unanimous: got data=%h valid=%b min=%b maj=%b, required 1234 1 0 0",
                     data_o, valid_o, min_err_o, maj_err_o);
        end
        idle(1);
        tests_run++;
        if (valid_o !== 1'b0 || data_o !== 32'h1234) begin
            tests_failed++;
            $display("FAIL data_hold: got data=%h valid=%b, required 1234 0", data_o, valid_o);
        end
    endtask

    task automatic test_minority();
        int hi;
        do_reset();
        drive(3'b111, lanes(32'hA, 32'hA, 32'hB), 1'b0, 1'b0);
        tests_run++;
        if (data_o !== 32'hA || maj_err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL minority_data: got data=%h maj=%b, required a 0", data_o, maj_err_o);
        end
        hi = int'(min_err_o);
        for (int i = 0; i < 7; i++) begin
            idle(1);
            hi += int'(min_err_o);
        end
        tests_run++;
        if (hi != HOLD + 1 || err_cnt_o !== 8'd1) begin
            tests_failed++;
            $display("FAIL minority_hold: got %0d high cycles cnt=%0d, required 5 cycles cnt=1", hi, err_cnt_o);
        end
    endtask

    task automatic test_invalid_lane();
        do_reset();
        drive(3'b011, lanes(32'h5, 32'h5, 32'h5), 1'b0, 1'b0);
        tests_run++;
        if (data_o !== 32'h5 || min_err_o !== 1'b1 || maj_err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL invalid_lane: got data=%h min=%b maj=%b, required 5 1 0", data_o, min_err_o, maj_err_o);
        end
    endtask

    task automatic test_mask();
        do_reset();
        for (int i = 0; i < 3; i++) drive(3'b111, lanes(32'h5, 32'h5, 32'h9), 1'b0, 1'b0);
        tests_run++;
        if (lane_fault_o !== 3'b100) begin
            tests_failed++;
            $display("FAIL mask_set: got fault=%b, required 100", lane_fault_o);
        end
        idle(6);
        drive(3'b111, lanes(32'h5, 32'h5, 32'h9), 1'b0, 1'b0);
        tests_run++;
        if (min_err_o !== 1'b0 || data_o !== 32'h5 || valid_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL masked_vote: got min=%b data=%h valid=%b, required 0 5 1", min_err_o, data_o, valid_o);
        end
    endtask

    // Relies on lane 2 being masked by test_mask.
    task automatic test_m_guard();
        for (int i = 0; i < 4; i++) drive(3'b011, lanes(32'h5, 32'h6, 32'h9), 1'b0, 1'b0);
        tests_run++;
        if (lane_fault_o !== 3'b100 || maj_err_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL m_guard: got fault=%b maj=%b, required 100 1", lane_fault_o, maj_err_o);
        end
        drive('0, '0, 1'b1, 1'b0);
        tests_run++;
        if (lane_fault_o !== 3'b000 || err_cnt_o !== 8'd0 || min_err_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL clear: got fault=%b cnt=%0d min=%b, required 000 0 1", lane_fault_o, err_cnt_o, min_err_o);
        end
    endtask

    task automatic test_majerr();
        int hi_min;
        int hi_maj;
        do_reset();
        drive(3'b111, lanes(32'h1, 32'h2, 32'h3), 1'b0, 1'b0);
        tests_run++;
        if (data_o !== 32'h1 || maj_err_o !== 1'b1 || min_err_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL majerr: got data=%h maj=%b min=%b, required 1 1 1", data_o, maj_err_o, min_err_o);
        end
        hi_min = int'(min_err_o);
        hi_maj = int'(maj_err_o);
        for (int i = 0; i < 7; i++) begin
            idle(1);
            hi_min += int'(min_err_o);
            hi_maj += int'(maj_err_o);
        end
        tests_run++;
        if (hi_min != HOLD + 1 || hi_maj != HOLD + 1) begin
            tests_failed++;
            $display("FAIL majerr_hold: got min %0d maj %0d cycles, required 5 and 5", hi_min, hi_maj);
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        drive(3'b111, lanes(32'hA, 32'hA, 32'hB), 1'b0, 1'b0);
        idle(2);
        drive(3'b111, lanes(32'hA, 32'hA, 32'hB), 1'b1, 1'b1);
        tests_run++;
        if ({data_o, valid_o, min_err_o, maj_err_o, lane_fault_o, err_cnt_o} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_hold: got data=%h valid=%b min=%b maj=%b fault=%b cnt=%0d, required all zero",
                     data_o, valid_o, min_err_o, maj_err_o, lane_fault_o, err_cnt_o);
        end
        idle(1);
        tests_run++;
        if (min_err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_flushed: got min=%b, required 0", min_err_o);
        end
    endtask

    task automatic test_clear_with_vote();
        do_reset();
        drive(3'b111, lanes(32'hA, 32'hA, 32'hB), 1'b0, 1'b0);
        drive(3'b111, lanes(32'hA, 32'hA, 32'hB), 1'b0, 1'b0);
        drive(3'b111, lanes(32'h7, 32'h7, 32'h8), 1'b1, 1'b0);
        tests_run++;
        if (data_o !== 32'h7 || min_err_o !== 1'b1 || err_cnt_o !== 8'd0 || lane_fault_o !== 3'b000) begin
            tests_failed++;
            $display("FAIL clear_vote: got data=%h min=%b cnt=%0d fault=%b, required 7 1 0 000",
                     data_o, min_err_o, err_cnt_o, lane_fault_o);
        end
        drive(3'b111, lanes(32'h7, 32'h7, 32'h8), 1'b0, 1'b0);
        drive(3'b111, lanes(32'h7, 32'h7, 32'h8), 1'b0, 1'b0);
        tests_run++;
        if (lane_fault_o !== 3'b000 || err_cnt_o !== 8'd2) begin
            tests_failed++;
            $display("FAIL streak_cleared: got fault=%b cnt=%0d, required 000 2", lane_fault_o, err_cnt_o);
        end
        drive(3'b111, lanes(32'h7, 32'h7, 32'h8), 1'b0, 1'b0);
        tests_run++;
        if (lane_fault_o !== 3'b100) begin
            tests_failed++;
            $display("FAIL streak_restart: got fault=%b, required 100", lane_fault_o);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 300; i++) drive(3'b111, lanes(32'h1, 32'h2, 32'h3), 1'b0, 1'b0);
        tests_run++;
        if (err_cnt_o !== 8'd255 || lane_fault_o !== 3'b001 || data_o !== 32'h2) begin
            tests_failed++;
            $display("FAIL saturation: got cnt=%0d fault=%b data=%h, required 255 001 2",
                     err_cnt_o, lane_fault_o, data_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0]     v;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
        logic             clr;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            v   = N'($urandom_range(0, 7));
            a   = WIDTH'($urandom_range(0, 3));
            b   = WIDTH'($urandom_range(0, 3));
            c   = WIDTH'($urandom_range(0, 3));
            clr = ($urandom_range(0, 15) == 0);
            drive(v, lanes(a, b, c), clr, 1'b0);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        clear        = 1'b0;
        lane_valid   = '0;
        lane_data    = '0;
        test_reset();
        test_unanimous();
        test_minority();
        test_invalid_lane();
        test_mask();
        test_m_guard();
        test_majerr();
        test_reset_mid_hold();
        test_clear_with_vote();
        test_saturation();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fatori_mon_voter.md
FATORI_MON_VOTER -- requirements
Module: fatori_mon_voter

Interface
REQ-001 SHALL have parameter N, default 3, meaning number of redundant lanes, legal range 2..7.
REQ-002 SHALL have parameter M, default 2, meaning minimum agreeing lanes for a valid vote, legal range 1..N.
REQ-003 SHALL have parameter WIDTH, default 32, meaning lane result width in bits.
REQ-004 SHALL have parameter HOLD, default 4, meaning extra cycles an error flag stays asserted after an event; 0 means a single-cycle pulse.
REQ-005 SHALL have parameter DISABLE_THR, default 3, meaning consecutive losing votes before a lane is masked; 0 disables masking.
REQ-006 SHALL have port clk_i  input  1  clock; reset is synchronous and active-high.
REQ-007 SHALL have port rst_i  input  1  synchronous active-high reset.
REQ-008 SHALL have port lane_valid_i  input  N  per-lane result valid.
REQ-009 SHALL have port lane_data_i  input  N*WIDTH  per-lane results; lane k occupies bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port clear_i  input  1  clears the lane mask, streak counters and error count.
REQ-011 SHALL have port data_o  output  WIDTH  voted result.
REQ-012 SHALL have port valid_o  output  1  data_o valid.
REQ-013 SHALL have port min_err_o  output  1  at least one participating lane disagreed, held per HOLD.
REQ-014 SHALL have port maj_err_o  output  1  no value reached M agreeing lanes, held per HOLD.
REQ-015 SHALL have port lane_fault_o  output  N  current lane mask; 1 means the lane is excluded.
REQ-016 SHALL have port err_cnt_o  output  8  saturating count of disagreeing votes.

Function
REQ-017 A vote SHALL occur in any cycle where at least one unmasked lane has lane_valid_i=1; participating lanes are all unmasked lanes.
REQ-018 An unmasked lane with lane_valid_i=0 during a vote SHALL count as disagreeing with every lane.
REQ-019 For each valid participating lane, the agreement count SHALL be the number of valid participating lanes with identical data, itself included.
REQ-020 The winner SHALL be the lowest-indexed lane whose agreement count is at least M.
REQ-021 If no lane reaches M, maj_err SHALL fire and data_o SHALL take the lowest-indexed valid participating lane.
REQ-022 Outputs SHALL be registered, giving 1-cycle latency: a vote in cycle t appears on data_o/valid_o in cycle t+1.
REQ-023 valid_o SHALL be 1 exactly in the cycle after a vote; data_o SHALL hold its last value when no vote occurs.
REQ-024 min_err SHALL fire on a vote where any participating lane disagrees with the winner, or on any maj_err.
REQ-025 An error flag SHALL assert in cycle t+1 and stay high through cycle t+1+HOLD; a new event while the flag is held SHALL restart the hold window.
REQ-026 Each lane SHALL have a streak counter that increments on a vote where the lane disagrees, or any maj_err vote, and clears on a vote where the lane agrees; the counter is unchanged when no vote occurs.
REQ-027 A lane SHALL be masked when its streak reaches DISABLE_THR, but only if at least M unmasked lanes would remain; otherwise the lane stays unmasked and its streak saturates at DISABLE_THR.
REQ-028 Masked lanes SHALL stay masked until clear_i or reset, and are ignored entirely.
REQ-029 err_cnt_o SHALL increment by 1 per vote with min_err and saturate at 255.
REQ-030 When clear_i and a vote occur in the same cycle, the vote SHALL use the pre-clear mask and its outputs/flags SHALL update normally; mask, streaks and err_cnt_o SHALL be zero in the next cycle.
REQ-031 clear_i SHALL NOT clear data_o, valid_o or held error flags.

Reset
REQ-032 With rst_i=1 at a clock edge, the next cycle SHALL show data_o=0, valid_o=0, min_err_o=0, maj_err_o=0, lane_fault_o=0, err_cnt_o=0, all streaks and hold counters at 0.
REQ-033 Reset SHALL take priority over clear_i and any vote in the same cycle, including mid-hold windows.

Verification
REQ-034 N=3, M=2: all lanes valid with 0x1234 -> next cycle data_o=0x1234, valid_o=1, min_err_o=0, maj_err_o=0.
REQ-035 Lanes {0xA,0xA,0xB} -> data_o=0xA, min_err_o high for 5 cycles (HOLD=4), err_cnt_o=1.
REQ-036 Lane 2 loses 3 consecutive votes -> lane_fault_o=3'b100; subsequent {0x5,0x5,0x9} votes produce min_err_o=0.
REQ-037 Lanes {0x1,0x2,0x3} -> data_o=0x1, maj_err_o=1 and min_err_o=1, each held for 5 cycles.
REQ-038 Lane 2 already masked and lane 1 loses 3 votes -> lane_fault_o stays 3'b100 (M guard); clear_i -> lane_fault_o=0, err_cnt_o=0.
REQ-039 rst_i asserted 2 cycles into a hold window -> all outputs 0 on the next cycle; err_cnt_o saturation is checked by 300 disagreeing votes -> 255.
